// File: rtl/uart_rx_block.sv
// uart_rx_block
//   Receive-side UART front end for the register-map bridge. It turns the
//   asynchronous rx line into 8N1 bytes, sent LSB first. After the last good
//   byte it raises a one-shot block-timeout strobe once the line has stayed
//   idle for TIMEOUT_BITS bit periods.
//
// Ports
//   clk              system clock
//   rst_n            asynchronous, active-low reset
//   rx               serial line, idle high, not synchronised to clk
//   rx_data_out      last good byte; holds until the next good byte
//   rx_data_valid    1-cycle strobe: rx_data_out updated this cycle
//   rx_block_timeout 1-cycle strobe: idle timeout after the last good byte
//   rx_frame_error   1-cycle strobe: stop bit sampled low
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, each start, data and stop sample is
//                        the 2-of-3 majority of rxs around the sample cycle.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | line idle, waiting for rxs low; runs the idle timeout
// START | waiting half a bit period to confirm the start bit
// DATA  | shifting in 8 data bits, one per bit period
// STOP  | sampling the stop bit
// BREAK | stop bit was low; waiting for the line to return high
`timescale 1ns/1ps
module uart_rx_block #(
  parameter int CLK_FREQ_HZ  = 27_000_000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data_out,
  output logic       rx_data_valid,
  output logic       rx_block_timeout,
  output logic       rx_frame_error
);

  localparam int DIV    = (CLK_FREQ_HZ + BAUD_RATE/2) / BAUD_RATE;
  localparam int HALF   = DIV / 2;
  localparam int TO_CYC = TIMEOUT_BITS * DIV;
  localparam int BW     = $clog2(DIV);
  localparam int TW     = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            to_q, to_d;
  logic            armed_q, armed_d;
  logic [TW-1:0]   idle_q, idle_d;
  logic            sync1_q, rxs_q;
  logic            samp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rx;
      rxs_q   <= sync1_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // sync1_q already holds next cycle's rxs, so the sample+1 term is free and
  // strobe timing does not move.
  logic rxs_d1_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rxs_d1_q <= 1'b1;
    else        rxs_d1_q <= rxs_q;
  end
  assign samp = (rxs_d1_q & rxs_q) | (rxs_d1_q & sync1_q) | (rxs_q & sync1_q);
`else
  assign samp = rxs_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      to_q    <= 1'b0;
      armed_q <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      to_q    <= to_d;
      armed_q <= armed_d;
      idle_q  <= idle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    to_d    = 1'b0;
    armed_d = armed_q;
    idle_d  = idle_q;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!rxs_q) state_d = START;
      end
      START: begin
        if (baud_q == BW'(HALF - 1)) begin
          baud_d = '0;
          bit_d  = '0;
          state_d = samp ? IDLE : DATA;
        end
      end
      DATA: begin
        if (baud_q == BW'(DIV - 1)) begin
          baud_d  = '0;
          shift_d = {samp, shift_q[7:1]};
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      STOP: begin
        if (baud_q == BW'(DIV - 1)) begin
          baud_d = '0;
          if (samp) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        baud_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A start edge in the same cycle as the terminal count wins: the counter
    // clears and the timeout is dropped, but armed stays for the next idle.
    if (valid_d) begin
      armed_d = 1'b1;
      idle_d  = '0;
    end else if (state_q == IDLE && state_d != IDLE) begin
      idle_d = '0;
    end else if (state_q == IDLE && armed_q) begin
      if (idle_q == TW'(TO_CYC - 1)) begin
        to_d    = 1'b1;
        armed_d = 1'b0;
        idle_d  = '0;
      end else begin
        idle_d = idle_q + TW'(1);
      end
    end
  end

  assign rx_data_out      = data_q;
  assign rx_data_valid    = valid_q;
  assign rx_block_timeout = to_q;
  assign rx_frame_error   = ferr_q;

endmodule

// File: tb/tb_uart_rx_block.sv
`timescale 1ns/1ps
module tb_uart_rx_block;

  // 27 MHz / 115200 -> DIV = 234, HALF = 117; timeout = 20 * 234 = 4680.
  // Pin falls in cycle P -> rxs low in P+2 (= T0) -> stop sample at
  // T0+117+9*234 = P+2225 -> strobe visible in cycle P+2226.
  localparam int DIV     = 234;
  localparam int TO_CYC  = 4680;
  localparam int LAT     = 2226;
  localparam int FRAME   = 2340;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data_out;
  logic       rx_data_valid, rx_block_timeout, rx_frame_error;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  int          v_cyc[$];
  logic [7:0]  v_dat[$];
  int          t_cyc[$];
  int          f_cyc[$];

  uart_rx_block dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .rx               (rx),
    .rx_data_out      (rx_data_out),
    .rx_data_valid    (rx_data_valid),
    .rx_block_timeout (rx_block_timeout),
    .rx_frame_error   (rx_frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_data_valid) begin
      v_cyc.push_back(cyc);
      v_dat.push_back(rx_data_out);
    end
    if (rx_block_timeout) t_cyc.push_back(cyc);
    if (rx_frame_error)   f_cyc.push_back(cyc);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    v_cyc.delete();
    v_dat.delete();
    t_cyc.delete();
    f_cyc.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 with the line high again.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
    t0 = cyc;
    rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(DIV);
    end
    rx = stop;
    wait_cycles(DIV);
    rx = 1'b1;
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2;

    wait_cycles(3);
    #3;
    check_val("rst_data",  rx_data_out,      8'h00);
    check_val("rst_valid", rx_data_valid,    0);
    check_val("rst_to",    rx_block_timeout, 0);
    check_val("rst_ferr",  rx_frame_error,   0);
    rst_n = 1'b1;
    wait_cycles(5);

    // single byte + timeout
    clear_log();
    send_frame(8'hA5, 1'b1, t0);
    wait_cycles(6000);
    check_val("a5_nvalid", v_cyc.size(), 1);
    if (v_cyc.size() >= 1) begin
      check_val("a5_lat",  v_cyc[0] - t0, LAT);
      check_val("a5_data", v_dat[0], 8'hA5);
    end
    check_val("a5_nto", t_cyc.size(), 1);
    if (t_cyc.size() >= 1 && v_cyc.size() >= 1)
      check_val("a5_to_dly", t_cyc[0] - v_cyc[0], TO_CYC);
    check_val("a5_hold", rx_data_out, 8'hA5);

    // back-to-back bytes
    clear_log();
    send_frame(8'h81, 1'b1, t0);
    send_frame(8'h03, 1'b1, t1);
    send_frame(8'hFF, 1'b1, t2);
    wait_cycles(6000);
    check_val("b2b_nvalid", v_cyc.size(), 3);
    if (v_cyc.size() == 3) begin
      check_val("b2b_lat",   v_cyc[0] - t0, LAT);
      check_val("b2b_gap1",  v_cyc[1] - v_cyc[0], FRAME);
      check_val("b2b_gap2",  v_cyc[2] - v_cyc[1], FRAME);
      check_val("b2b_d0",    v_dat[0], 8'h81);
      check_val("b2b_d1",    v_dat[1], 8'h03);
      check_val("b2b_d2",    v_dat[2], 8'hFF);
    end
    check_val("b2b_nto", t_cyc.size(), 1);
    if (t_cyc.size() >= 1 && v_cyc.size() == 3)
      check_val("b2b_to_dly", t_cyc[0] - v_cyc[2], TO_CYC);

    // two bytes 4000 cycles apart, gap shorter than timeout
    clear_log();
    send_frame(8'h55, 1'b1, t0);
    wait_cycles(4000 - FRAME);
    send_frame(8'h66, 1'b1, t1);
    wait_cycles(6000);
    check_val("gap_start_sep", t1 - t0, 4000);
    check_val("gap_nvalid", v_cyc.size(), 2);
    if (v_cyc.size() == 2) begin
      check_val("gap_d0", v_dat[0], 8'h55);
      check_val("gap_d1", v_dat[1], 8'h66);
    end
    check_val("gap_nto", t_cyc.size(), 1);
    if (t_cyc.size() >= 1 && v_cyc.size() == 2)
      check_val("gap_to_dly", t_cyc[0] - v_cyc[1], TO_CYC);

    // 50-cycle glitch
    clear_log();
    rx = 1'b0;
    wait_cycles(50);
    rx = 1'b1;
    wait_cycles(400);
    check_val("gl_nvalid", v_cyc.size(), 0);
    check_val("gl_nferr",  f_cyc.size(), 0);
    check_val("gl_nto",    t_cyc.size(), 0);
    check_val("gl_hold",   rx_data_out, 8'h66);

    // frame error, then good byte
    clear_log();
    send_frame(8'h3C, 1'b0, t0);
    check_val("fe_nferr",  f_cyc.size(), 1);
    if (f_cyc.size() >= 1) check_val("fe_lat", f_cyc[0] - t0, LAT);
    check_val("fe_nvalid", v_cyc.size(), 0);
    check_val("fe_hold",   rx_data_out, 8'h66);
    wait_cycles(100);
    send_frame(8'h12, 1'b1, t1);
    wait_cycles(200);
    check_val("fe_nvalid2", v_cyc.size(), 1);
    if (v_cyc.size() >= 1) begin
      check_val("fe_d12",     v_dat[0], 8'h12);
      check_val("fe_d12_lat", v_cyc[0] - t1, LAT);
    end
    check_val("fe_nferr2", f_cyc.size(), 1);

    // reset in bit 4 while armed from the 0x12 byte
    clear_log();
    rx = 1'b0;
    wait_cycles(DIV);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      wait_cycles(DIV);
    end
    rx = 1'b1;
    wait_cycles(DIV / 2);
    rst_n = 1'b0;
    wait_cycles(2);
    #3;
    check_val("mr_data",  rx_data_out,      8'h00);
    check_val("mr_valid", rx_data_valid,    0);
    check_val("mr_to",    rx_block_timeout, 0);
    check_val("mr_ferr",  rx_frame_error,   0);
    wait_cycles(2);
    rst_n = 1'b1;
    wait_cycles(6000);
    check_val("mr_nto_idle",   t_cyc.size(), 0);
    check_val("mr_nvalid_idle", v_cyc.size(), 0);
    send_frame(8'h5A, 1'b1, t0);
    wait_cycles(6000);
    check_val("mr_nvalid", v_cyc.size(), 1);
    if (v_cyc.size() >= 1) begin
      check_val("mr_d5a", v_dat[0], 8'h5A);
      check_val("mr_lat", v_cyc[0] - t0, LAT);
    end
    check_val("mr_nto", t_cyc.size(), 1);
    if (t_cyc.size() >= 1 && v_cyc.size() >= 1)
      check_val("mr_to_dly", t_cyc[0] - v_cyc[0], TO_CYC);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
